dechop_hold: RTL and testbench



---
 rtl/dechop_hold_pkg.sv | 14 +
 rtl/dechop_hold_lane.sv | 45 ++++
 rtl/dechop_hold.sv | 134 +++++++++++++
 tb/tb_dechop_hold.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dechop_hold_pkg.sv
// Shared defaults and state type for the dechop/hold acquisition slice.
// Optional feature macro used by this slice: DECHOP_SATURATE_EN.
package dechop_hold_pkg;

    localparam int ADC_DW             = 18;
    localparam int DECHOP_CAPTURE_CNT = 1;
    localparam int DECHOP_N_CH        = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PROC = 1'b1
    } dechop_state_t;

endpackage

// File: rtl/dechop_hold_lane.sv
// One-channel combinational sign/hold unit shared by all channels of dechop_hold.
// DECHOP_SATURATE_EN: negating the most negative code clamps to the most positive code.
module dechop_lane
    import dechop_hold_pkg::*;
#(
    parameter int DW = ADC_DW
) (
    input  logic [DW-1:0] sample,
    input  logic [DW-1:0] store,
    input  logic          chop,
    input  logic          hold,
    input  logic          en,
    output logic [DW-1:0] out,
    output logic          held,
    output logic          store_we
);

    logic [DW-1:0] neg;

    always_comb begin
        neg = '0 - sample;
`ifdef DECHOP_SATURATE_EN
        if (sample == {1'b1, {(DW-1){1'b0}}}) begin
            neg = {1'b0, {(DW-1){1'b1}}};
        end
`endif
    end

    // With demodulation disabled the store still tracks raw data so a later hold replays it.
    always_comb begin
        out      = sample;
        held     = 1'b0;
        store_we = 1'b1;
        if (en) begin
            if (hold) begin
                out      = store;
                held     = 1'b1;
                store_we = 1'b0;
            end else if (chop) begin
                out = neg;
            end
        end
    end

endmodule

// File: rtl/dechop_hold.sv
// Snapshots N_CH ADC channels once per period and emits them serially, dechopped or held.
// Optional feature macro: DECHOP_SATURATE_EN (saturating negation inside dechop_lane).
module dechop_hold
    import dechop_hold_pkg::*;
#(
    parameter int N_CH        = DECHOP_N_CH,
    parameter int DW          = ADC_DW,
    parameter int CAPTURE_CNT = DECHOP_CAPTURE_CNT
) (
    input  logic              adc_data_clk,
    input  logic              reset_n,
    input  logic [5:0]        adc_clk_cnt,
    input  logic              chop_en,
    input  logic              chop_dly_i,
    input  logic              data_hold_i,
    input  logic [N_CH*DW-1:0] adc_data_i,
    output logic [DW-1:0]     dout,
    output logic [5:0]        dout_ch,
    output logic              dout_valid,
    output logic              dout_held,
    output logic              frame_done,
    output logic              overrun
);

    localparam int         CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [5:0] LAST_CH = 6'(N_CH - 1);
    localparam logic [5:0] CAP_CNT = 6'(CAPTURE_CNT);

    dechop_state_t state, state_next;
    logic [5:0]    ch, ch_next;

    logic [DW-1:0] snap_data [N_CH];
    logic          snap_chop;
    logic          snap_hold;
    logic          snap_en;
    logic [DW-1:0] store [N_CH];

    logic          snap_fire;
    logic          proc_fire;
    logic          proc_last;
    logic [CW-1:0] ch_idx;
    logic [DW-1:0] lane_out;
    logic          lane_held;
    logic          lane_we;

    assign snap_fire = (adc_clk_cnt == CAP_CNT);
    assign ch_idx    = ch[CW-1:0];

    always_ff @(posedge adc_data_clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            ch    <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
        end
    end

    // A snapshot always restarts the frame at channel 0, even mid-frame.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        if (snap_fire) begin
            state_next = ST_PROC;
            ch_next    = '0;
        end else if (state == ST_PROC) begin
            if (ch == LAST_CH) begin
                state_next = ST_IDLE;
                ch_next    = '0;
            end else begin
                ch_next = ch + 6'd1;
            end
        end
    end

    always_comb begin
        proc_fire = (state == ST_PROC) && !snap_fire;
        proc_last = proc_fire && (ch == LAST_CH);
    end

    dechop_lane #(
        .DW (DW)
    ) u_lane (
        .sample   (snap_data[ch_idx]),
        .store    (store[ch_idx]),
        .chop     (snap_chop),
        .hold     (snap_hold),
        .en       (snap_en),
        .out      (lane_out),
        .held     (lane_held),
        .store_we (lane_we)
    );

    always_ff @(posedge adc_data_clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                snap_data[i] <= '0;
                store[i]     <= '0;
            end
            snap_chop  <= 1'b0;
            snap_hold  <= 1'b0;
            snap_en    <= 1'b0;
            dout       <= '0;
            dout_ch    <= '0;
            dout_valid <= 1'b0;
            dout_held  <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (snap_fire) begin
                for (int unsigned i = 0; i < N_CH; i++) begin
                    snap_data[i] <= adc_data_i[i*DW +: DW];
                end
                snap_chop <= chop_dly_i;
                snap_hold <= data_hold_i;
                snap_en   <= chop_en;
                if (state == ST_PROC) begin
                    overrun <= 1'b1;
                end
            end
            if (proc_fire) begin
                dout      <= lane_out;
                dout_ch   <= ch;
                dout_held <= lane_held;
                if (lane_we) begin
                    store[ch_idx] <= lane_out;
                end
            end
            dout_valid <= proc_fire;
            frame_done <= proc_last;
        end
    end

endmodule

// File: tb/tb_dechop_hold.sv
// Directed scoreboard bench for dechop_hold (N_CH=4, DW=18, CAPTURE_CNT=1).
module tb_dechop_hold;

    localparam int N_CH = 4;
    localparam int DW   = 18;

    typedef logic [DW-1:0] word_t;
    typedef word_t frame_t [N_CH];

    typedef struct {
        logic [5:0]    ch;
        logic [DW-1:0] data;
        logic          held;
        logic          last;
        int            cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [5:0]        adc_clk_cnt;
    logic              chop_en;
    logic              chop_dly_i;
    logic              data_hold_i;
    logic [N_CH*DW-1:0] adc_data_i;
    logic [DW-1:0]     dout;
    logic [5:0]        dout_ch;
    logic              dout_valid;
    logic              dout_held;
    logic              frame_done;
    logic              overrun;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;

    always #6 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dechop_hold #(
        .N_CH        (N_CH),
        .DW          (DW),
        .CAPTURE_CNT (1)
    ) dut (
        .adc_data_clk (clk),
        .reset_n      (reset_n),
        .adc_clk_cnt  (adc_clk_cnt),
        .chop_en      (chop_en),
        .chop_dly_i   (chop_dly_i),
        .data_hold_i  (data_hold_i),
        .adc_data_i   (adc_data_i),
        .dout         (dout),
        .dout_ch      (dout_ch),
        .dout_valid   (dout_valid),
        .dout_held    (dout_held),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t w(input int v);
        return v[DW-1:0];
    endfunction

    task automatic drive(input frame_t s);
        for (int c = 0; c < N_CH; c++) adc_data_i[c*DW +: DW] = s[c];
    endtask

    task automatic push(input int ch, input word_t d, input logic held, input int at);
        exp_t e;
        e.ch   = 6'(ch);
        e.data = d;
        e.held = held;
        e.last = (ch == N_CH - 1);
        e.cyc  = at;
        sbq.push_back(e);
    endtask

    task automatic scramble();
        for (int c = 0; c < N_CH; c++) adc_data_i[c*DW +: DW] = w(int'($urandom));
        chop_en     = ~chop_en;
        chop_dly_i  = ~chop_dly_i;
        data_hold_i = ~data_hold_i;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, dout_valid, 0);
        chk({tag, "_dout"}, dout, 0);
        chk({tag, "_ch"}, dout_ch, 0);
        chk({tag, "_held"}, dout_held, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Runs one full ADC period; snapshot edge E is the posedge after cnt=1 is driven.
    task automatic run_frame(input frame_t s, input logic en, input logic chop, input logic hold,
                             input frame_t exp, input logic exp_held, input bit reset_mid);
        int e;
        @(negedge clk);
        adc_clk_cnt = 6'd0;
        chop_en     = en;
        chop_dly_i  = chop;
        data_hold_i = hold;
        drive(s);
        @(negedge clk);
        adc_clk_cnt = 6'd1;
        e = cyc + 1;
        for (int k = 0; k < (reset_mid ? 2 : N_CH); k++) push(k, exp[k], exp_held, e + 1 + k);
        @(negedge clk);
        adc_clk_cnt = 6'd2;
        scramble();
        if (reset_mid) begin
            @(negedge clk);
            adc_clk_cnt = 6'd3;
            @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            check_reset_outputs("midreset");
            reset_n = 1'b1;
            for (int i = 5; i < 40; i++) begin
                @(negedge clk);
                adc_clk_cnt = 6'(i);
            end
        end else begin
            for (int i = 3; i < 40; i++) begin
                @(negedge clk);
                adc_clk_cnt = 6'(i);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (dout_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", dout_valid, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("dout_ch", dout_ch, mon_e.ch);
                    chk("dout", dout, mon_e.data);
                    chk("dout_held", dout_held, mon_e.held);
                    chk("frame_done", frame_done, mon_e.last);
                    chk("latency", cyc, mon_e.cyc);
                end
            end else begin
                if (frame_done) chk("stray_frame_done", frame_done, 0);
                if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                    mon_e = sbq.pop_front();
                    chk("missing_output", dout_valid, 1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t s, x;
        int     e;
        reset_n     = 1'b0;
        adc_clk_cnt = 6'd0;
        chop_en     = 1'b0;
        chop_dly_i  = 1'b0;
        data_hold_i = 1'b0;
        adc_data_i  = '0;
        mon_en      = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        s = '{w(100), w(-5), w(0), w(7)};
        run_frame(s, 1'b1, 1'b0, 1'b0, s, 1'b0, 1'b0);

        x = '{w(-100), w(5), w(0), w(-7)};
        run_frame(s, 1'b1, 1'b1, 1'b0, x, 1'b0, 1'b0);

        s = '{w(1), w(1), w(1), w(1)};
        run_frame(s, 1'b1, 1'b1, 1'b1, x, 1'b1, 1'b0);

        s = '{w(-131072), w(131071), w(-1), w(3)};
`ifdef DECHOP_SATURATE_EN
        x = '{w(131071), w(-131071), w(1), w(-3)};
`else
        x = '{w(-131072), w(-131071), w(1), w(-3)};
`endif
        run_frame(s, 1'b1, 1'b1, 1'b0, x, 1'b0, 1'b0);

        s = '{w(42), w(-9), w(0), w(5)};
        run_frame(s, 1'b0, 1'b1, 1'b1, s, 1'b0, 1'b0);

        x = s;
        s = '{w(77), w(77), w(77), w(77)};
        run_frame(s, 1'b1, 1'b0, 1'b1, x, 1'b1, 1'b0);

        s = '{w(11), w(22), w(33), w(44)};
        run_frame(s, 1'b1, 1'b0, 1'b0, s, 1'b0, 1'b1);

        s = '{w(9), w(9), w(9), w(9)};
        x = '{w(0), w(0), w(0), w(0)};
        run_frame(s, 1'b1, 1'b0, 1'b1, x, 1'b1, 1'b0);
        chk("overrun_clear", overrun, 0);

        // Second snapshot lands one channel into the frame.
        @(negedge clk);
        adc_clk_cnt = 6'd0;
        chop_en     = 1'b1;
        chop_dly_i  = 1'b0;
        data_hold_i = 1'b0;
        s = '{w(5), w(6), w(7), w(8)};
        drive(s);
        @(negedge clk);
        adc_clk_cnt = 6'd1;
        e = cyc + 1;
        push(0, w(5), 1'b0, e + 1);
        @(negedge clk);
        adc_clk_cnt = 6'd2;
        @(negedge clk);
        adc_clk_cnt = 6'd1;
        chop_dly_i  = 1'b1;
        s = '{w(9), w(10), w(11), w(12)};
        drive(s);
        x = '{w(-9), w(-10), w(-11), w(-12)};
        for (int k = 0; k < N_CH; k++) push(k, x[k], 1'b0, e + 3 + k);
        for (int i = 2; i < 40; i++) begin
            @(negedge clk);
            adc_clk_cnt = 6'(i);
        end
        chk("overrun_set", overrun, 1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
